// File: rtl/skyhop_pkg.sv
// Shared SkyHop constants: column geometry, vertical limits, jump_ctrl
// state encoding and the column-to-x helper used by the renderers.
// Optional feature macro: JUMP_CTRL_GRAVITY_FALL_EN (accelerating fall).
package skyhop_pkg;

    localparam int COLS  = 8;
    localparam int COL_W = 3;
    localparam int V0_I  = 7;

    localparam logic [10:0]        X0        = 11'd40;
    localparam logic [10:0]        COL_PITCH = 11'd60;
    localparam logic [10:0]        X_DX      = 11'd4;
    localparam logic [9:0]         Y_BASE    = 10'd400;
    localparam logic [9:0]         Y_FLOOR   = 10'd560;
    localparam logic signed [10:0] Y_FLOOR_S = 11'sd560;
    localparam logic signed [4:0]  V0        = 5'(V0_I);
    // A hop lasts 2*V0+1 frame ticks so the parabola closes exactly.
    localparam logic [3:0]         FLY_STEPS = 4'(2 * V0_I + 1);
`ifdef JUMP_CTRL_GRAVITY_FALL_EN
    localparam logic signed [4:0]  VMAX      = 5'sd15;
`else
    localparam logic signed [10:0] FALL_DY   = 11'sd8;
`endif
    localparam logic [COL_W-1:0]   COL_MID   = 3'(COLS / 2);
    localparam logic [COL_W-1:0]   COL_LAST  = 3'(COLS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FLY  = 2'd1,
        ST_LAND = 2'd2,
        ST_FALL = 2'd3
    } jc_state_e;

    typedef enum logic [1:0] {
        DIR_NONE  = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_RIGHT = 2'd2
    } jc_dir_e;

    // Screen x of the left edge of a block column.
    function automatic logic [10:0] col_to_x(input logic [COL_W-1:0] col);
        col_to_x = X0 + COL_PITCH * {8'd0, col};
    endfunction

endpackage

// File: rtl/jump_step.sv
// Per-frame position/velocity step for the jumping character.
// Fly: ballistic y update and horizontal drift. Fall: constant speed, or
// continued gravity with a speed cap when JUMP_CTRL_GRAVITY_FALL_EN is set.
// y is always clamped to [0, Y_FLOOR].
module jump_step
    import skyhop_pkg::*;
(
    input  logic              i_fall,
    input  logic [9:0]        i_y,
    input  logic signed [4:0] i_vy,
    input  logic [10:0]       i_x,
    input  jc_dir_e           i_dir,
    output logic [9:0]        o_y,
    output logic signed [4:0] o_vy,
    output logic [10:0]       o_x,
    output logic              o_floor
);

    logic signed [10:0] w_y_ext;
    logic signed [10:0] w_vy_ext;
    logic signed [10:0] w_y_raw;

    // Next position/velocity for one frame tick, then clamp y to the playfield.
    always_comb begin
        w_y_ext  = signed'({1'b0, i_y});
        w_vy_ext = signed'({{6{i_vy[4]}}, i_vy});
        w_y_raw  = w_y_ext - w_vy_ext;
        o_vy     = i_vy - 5'sd1;
        o_x      = i_x;
        if (i_fall) begin
`ifdef JUMP_CTRL_GRAVITY_FALL_EN
            if (i_vy <= -VMAX) begin
                o_vy = -VMAX;
            end else begin
                o_vy = i_vy - 5'sd1;
            end
`else
            w_y_raw = w_y_ext + FALL_DY;
            o_vy    = i_vy;
`endif
        end else begin
            case (i_dir)
                DIR_RIGHT: o_x = i_x + X_DX;
                DIR_LEFT:  o_x = i_x - X_DX;
                default:   o_x = i_x;
            endcase
        end
        if (w_y_raw < 11'sd0) begin
            o_y = 10'd0;
        end else if (w_y_raw > Y_FLOOR_S) begin
            o_y = Y_FLOOR;
        end else begin
            o_y = w_y_raw[9:0];
        end
        o_floor = (o_y == Y_FLOOR);
    end

endmodule

// File: rtl/jump_ctrl.sv
// SkyHop jump sequencer: turns one-cycle jump commands into per-frame
// character motion, evaluates the landing against the block map and
// animates the fall after a miss. Positions only move on frame ticks.
// Optional feature macro: JUMP_CTRL_GRAVITY_FALL_EN (see jump_step).
module jump_ctrl
    import skyhop_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_tick,
    input  logic             map_reset,
    input  logic             jump_left,
    input  logic             jump_right,
    input  logic             block_present,
    output logic [COL_W-1:0] target_col,
    output logic [COL_W-1:0] cur_col,
    output logic [10:0]      char_x,
    output logic [9:0]       char_y,
    output logic             character_landed,
    output logic             jump_fail
);

    localparam logic [10:0] X_MID = col_to_x(COL_MID);

    jc_state_e         r_state, w_state_nxt;
    logic [COL_W-1:0]  r_cur_col, w_cur_col_nxt;
    logic [COL_W-1:0]  r_target_col, w_target_col_nxt;
    logic [10:0]       r_x, w_x_nxt;
    logic [9:0]        r_y, w_y_nxt;
    logic signed [4:0] r_vy, w_vy_nxt;
    logic [3:0]        r_step, w_step_nxt;
    logic              r_landed, w_landed_nxt;
    logic              r_fail, w_fail_nxt;

    jc_dir_e           w_dir;
    logic [9:0]        w_step_y;
    logic signed [4:0] w_step_vy;
    logic [10:0]       w_step_x;
    logic              w_step_floor;

    // Horizontal direction of the hop follows from where it lands.
    always_comb begin
        if (r_target_col > r_cur_col) begin
            w_dir = DIR_RIGHT;
        end else if (r_target_col < r_cur_col) begin
            w_dir = DIR_LEFT;
        end else begin
            w_dir = DIR_NONE;
        end
    end

    jump_step u_step (
        .i_fall  (r_state == ST_FALL),
        .i_y     (r_y),
        .i_vy    (r_vy),
        .i_x     (r_x),
        .i_dir   (w_dir),
        .o_y     (w_step_y),
        .o_vy    (w_step_vy),
        .o_x     (w_step_x),
        .o_floor (w_step_floor)
    );

    // Next-state and datapath decisions; map_reset overrides every state.
    always_comb begin
        w_state_nxt      = r_state;
        w_cur_col_nxt    = r_cur_col;
        w_target_col_nxt = r_target_col;
        w_x_nxt          = r_x;
        w_y_nxt          = r_y;
        w_vy_nxt         = r_vy;
        w_step_nxt       = r_step;
        w_landed_nxt     = 1'b0;
        w_fail_nxt       = r_fail;
        if (map_reset) begin
            w_state_nxt      = ST_IDLE;
            w_cur_col_nxt    = COL_MID;
            w_target_col_nxt = COL_MID;
            w_x_nxt          = X_MID;
            w_y_nxt          = Y_BASE;
            w_vy_nxt         = 5'sd0;
            w_step_nxt       = 4'd0;
            w_fail_nxt       = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (jump_left ^ jump_right) begin
                        w_state_nxt = ST_FLY;
                        w_vy_nxt    = V0;
                        w_step_nxt  = 4'd0;
                        // A jump off either edge turns into a vertical hop.
                        if (jump_left) begin
                            if (r_cur_col == 3'd0) begin
                                w_target_col_nxt = r_cur_col;
                            end else begin
                                w_target_col_nxt = r_cur_col - 3'd1;
                            end
                        end else begin
                            if (r_cur_col == COL_LAST) begin
                                w_target_col_nxt = r_cur_col;
                            end else begin
                                w_target_col_nxt = r_cur_col + 3'd1;
                            end
                        end
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_FLY: begin
                    if (frame_tick) begin
                        w_x_nxt    = w_step_x;
                        w_y_nxt    = w_step_y;
                        w_vy_nxt   = w_step_vy;
                        w_step_nxt = r_step + 4'd1;
                        if (r_step == FLY_STEPS - 4'd1) begin
                            w_state_nxt = ST_LAND;
                        end else begin
                            w_state_nxt = ST_FLY;
                        end
                    end else begin
                        w_state_nxt = ST_FLY;
                    end
                end
                ST_LAND: begin
                    w_landed_nxt = 1'b1;
                    if (block_present) begin
                        w_cur_col_nxt = r_target_col;
                        w_state_nxt   = ST_IDLE;
                    end else begin
                        w_fail_nxt  = 1'b1;
                        w_state_nxt = ST_FALL;
                    end
                end
                ST_FALL: begin
                    if (frame_tick) begin
                        w_y_nxt  = w_step_y;
                        w_vy_nxt = w_step_vy;
                        if (w_step_floor) begin
                            w_landed_nxt = 1'b1;
                            w_fail_nxt   = 1'b0;
                            w_state_nxt  = ST_IDLE;
                        end else begin
                            w_state_nxt = ST_FALL;
                        end
                    end else begin
                        w_state_nxt = ST_FALL;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers; async reset recentres the character.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_cur_col    <= COL_MID;
            r_target_col <= COL_MID;
            r_x          <= X_MID;
            r_y          <= Y_BASE;
            r_vy         <= 5'sd0;
            r_step       <= 4'd0;
            r_landed     <= 1'b0;
            r_fail       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cur_col    <= w_cur_col_nxt;
            r_target_col <= w_target_col_nxt;
            r_x          <= w_x_nxt;
            r_y          <= w_y_nxt;
            r_vy         <= w_vy_nxt;
            r_step       <= w_step_nxt;
            r_landed     <= w_landed_nxt;
            r_fail       <= w_fail_nxt;
        end
    end

    assign target_col       = r_target_col;
    assign cur_col          = r_cur_col;
    assign char_x           = r_x;
    assign char_y           = r_y;
    assign character_landed = r_landed;
    assign jump_fail        = r_fail;

endmodule

// File: doc/jump_ctrl.md
# jump_ctrl

Sequences the character's hop between block columns for the SkyHop game. It turns the one-cycle `jump_left`/`jump_right` commands from the game state machine into per-frame character position updates. At landing it checks the block map and returns `character_landed`/`jump_fail`. On a failed landing it animates the fall to the floor. It sits between the game state machine and the character/block renderers, and is paced by the VGA frame tick.

## Interface
- `COLS`, 8: number of block columns; the column index is 3 bits.
- `V0`, 7: initial upward velocity in px/frame; flight lasts 2·V0+1 frame ticks.
- `X_DX`, 4: horizontal px per frame; column pitch is X_DX·(2·V0+1) = 60.
- `X0`, 40: x of column 0.
- `Y_BASE`, 400: standing y.
- `Y_FLOOR`, 560: fall end y.
- `FALL_DY`, 8: constant fall speed in px/frame (macro off).
- `VMAX`, 15: fall speed limit (macro on).
- `clk` in 1: system clock; the only clock.
- `rst` in 1: asynchronous, active-low reset.
- `frame_tick` in 1: one-cycle pulse per video frame.
- `map_reset` in 1: one-cycle pulse from PREPARE_MAP; recentres the character.
- `jump_left` in 1: jump command from the game state machine.
- `jump_right` in 1: jump command from the game state machine.
- `block_present` in 1: block map lookup for `target_col`; valid in the same cycle.
- `target_col` out 3: column the current or next jump lands on.
- `cur_col` out 3: column the character stands on.
- `char_x` out 11: character x position.
- `char_y` out 10: character y position.
- `character_landed` out 1: one-cycle pulse.
- `jump_fail` out 1: level signal.

## Operation
- States:
  - IDLE: waiting for a jump command.
  - FLY: hop in progress.
  - LAND: single-cycle landing evaluation.
  - FALL: falling after a failed landing.
- Reset values: state IDLE, `cur_col`=`target_col`=COLS/2=4, `char_x`=X0+4·60=280, `char_y`=Y_BASE, vy=0, step counter=0, `character_landed`=0, `jump_fail`=0.
- `map_reset`:
  - Highest priority, accepted in any state.
  - Restores all reset values on the next edge.
- Starting a jump:
  - Accepted only in IDLE when exactly one of `jump_left`/`jump_right` is high.
  - Both high, or a command outside IDLE: ignored.
  - Effect: vy←V0, step←0, `target_col`←`cur_col`∓1, next state FLY.
- Edge columns: jump left at col 0 or jump right at col COLS-1 becomes a vertical hop. `target_col`=`cur_col`, x delta 0, same duration.
- FLY, on each `frame_tick`:
  - y←y−vy, vy←vy−1, x←x±X_DX (0 for a vertical hop), step←step+1.
  - The tick that completes step 2·V0+1 moves to LAND.
  - y has then returned exactly to Y_BASE; x is exactly X0+60·`target_col`.
- LAND (one cycle):
  - Sample `block_present`; pulse `character_landed`.
  - Block present: `cur_col`←`target_col`, `jump_fail` stays 0, go IDLE.
  - Block absent: `jump_fail`←1, go FALL.
- FALL, on each `frame_tick`:
  - y←min(y+FALL_DY, Y_FLOOR).
  - The tick reaching Y_FLOOR pulses `character_landed`, clears `jump_fail`, and goes IDLE.
- Arithmetic:
  - vy is 5-bit signed; the y update is computed 11-bit signed, then clamped to [0, Y_FLOOR].
  - x is unsigned 11-bit; it cannot wrap because of the edge rule.

## Timing
- A command at edge t is reflected in FLY at t+1.
- The first motion happens on the first `frame_tick` strictly after t+1. A tick coincident with the command is not a motion step.
- `character_landed` and `jump_fail` are registered and change on the same edge that leaves LAND (or the final FALL tick).
- `jump_fail` is stable before the game state machine samples it in GAME_IDLE.
- `char_x`/`char_y` change only on `frame_tick` edges, plus reset and `map_reset`. This keeps them tear-free for the renderer.
- `frame_tick` arriving in LAND is absorbed; LAND always lasts exactly one cycle.
- A `rst` assertion mid-flight or mid-fall forces reset values immediately, asynchronously.

## Configuration
- `JUMP_CTRL_GRAVITY_FALL_EN`:
  - Defined: FALL continues the gravity update, y←y−vy and vy←max(vy−1, −VMAX), clamped at Y_FLOOR. The fall accelerates from vy=−8.
  - Undefined: constant FALL_DY per tick; VMAX unused.

## Structure
- Shared package `skyhop_pkg` holds:
  - the jump_ctrl state encoding;
  - COLS, the column index width, X0, the column pitch, Y_BASE and Y_FLOOR, shared with the block and character renderers.
- One sub-module, `jump_step`: combinational per-tick next-position/velocity/clamp calculation (fly and fall variants).
- The FSM, counters and registers stay in `jump_ctrl`.

## Test plan
- Reset, then `map_reset` → `cur_col`=4, `char_x`=280, `char_y`=400, outputs low; no motion without a command.
- `jump_right` at col 4 with `block_present`=1:
  - after 8 ticks, `char_y`=372;
  - after 15 ticks, `char_x`=340, `char_y`=400;
  - one `character_landed` pulse, `cur_col`=5, `jump_fail`=0.
- `jump_left` at col 0 → x stays 40 throughout, `target_col`=0, landing after 15 ticks.
- `block_present`=0 at landing, macro off:
  - landed pulse, then `jump_fail`=1;
  - 20 ticks later `char_y`=560 with a second landed pulse, `jump_fail`=0.
- `jump_left` and `jump_right` together, or `jump_right` issued mid-flight → ignored; flight still completes in 15 ticks.
- `rst` low at flight tick 6 → immediate reset values; `map_reset` during FALL → recentred, state IDLE.
